// File: rtl/writeback_stage_if.sv
// Bundle interface between the memory stage and the writeback stage.
// The master side drives the *_mem bundle and observes the *_wb results;
// the slave side (the writeback stage) does the opposite.
interface writeback_stage_if #(
   parameter int WIDTH          = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      valid_mem;
   logic [WIDTH-1:0]          pc_mem;
   logic                      rd_mem;
   logic [REG_ADDR_WIDTH-1:0] rd_address_mem;
   logic [2:0]                src_sel_mem;
   logic [WIDTH-1:0]          alu_result_mem;
   logic [WIDTH-1:0]          read_data_mem;
   logic [1:0]                load_size_mem;
   logic                      load_signed_mem;
   logic [1:0]                byte_offset_mem;
   logic [1:0]                hilo_we_mem;
   logic [WIDTH-1:0]          hi_data_mem;
   logic [WIDTH-1:0]          lo_data_mem;

   logic                      valid_wb;
   logic [WIDTH-1:0]          pc_wb;
   logic                      rd_wb;
   logic [REG_ADDR_WIDTH-1:0] rd_address_wb;
   logic [WIDTH-1:0]          rd_data_wb;
   logic [WIDTH-1:0]          hi;
   logic [WIDTH-1:0]          lo;
   logic [WIDTH-1:0]          retired_count;

   modport master (
      output valid_mem, pc_mem, rd_mem, rd_address_mem, src_sel_mem,
             alu_result_mem, read_data_mem, load_size_mem, load_signed_mem,
             byte_offset_mem, hilo_we_mem, hi_data_mem, lo_data_mem,
      input  valid_wb, pc_wb, rd_wb, rd_address_wb, rd_data_wb,
             hi, lo, retired_count
   );

   modport slave (
      input  valid_mem, pc_mem, rd_mem, rd_address_mem, src_sel_mem,
             alu_result_mem, read_data_mem, load_size_mem, load_signed_mem,
             byte_offset_mem, hilo_we_mem, hi_data_mem, lo_data_mem,
      output valid_wb, pc_wb, rd_wb, rd_address_wb, rd_data_wb,
             hi, lo, retired_count
   );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result selection, load extraction,
// HI/LO ownership and a retired-instruction counter. All outputs are
// registered; a global stall freezes every register in the stage.
module writeback_stage #(
   parameter int WIDTH          = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LINK_OFFSET    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   writeback_stage_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE_W         = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] LINK_OFFSET_W = WIDTH'(LINK_OFFSET);

   // Pick the addressed byte/halfword out of the aligned little-endian word
   // and extend it; the low offset bit is ignored for halfwords.
   function automatic logic [WIDTH-1:0] extract_load(
      input logic [WIDTH-1:0] word,
      input logic [1:0]       size,
      input logic             sign_ext,
      input logic [1:0]       off
   );
      logic [7:0]       byte_v;
      logic [15:0]      half_v;
      logic [WIDTH-1:0] res_v;
      case (off)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         2'd3:    byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      half_v = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    res_v = {{(WIDTH-8){sign_ext & byte_v[7]}}, byte_v};
         2'd1:    res_v = {{(WIDTH-16){sign_ext & half_v[15]}}, half_v};
         default: res_v = word;
      endcase
      return res_v;
   endfunction

   logic                      valid_wb_r;
   logic [WIDTH-1:0]          pc_wb_r;
   logic                      rd_wb_r;
   logic [REG_ADDR_WIDTH-1:0] rd_address_wb_r;
   logic [WIDTH-1:0]          rd_data_wb_r;
   logic [WIDTH-1:0]          hi_r;
   logic [WIDTH-1:0]          lo_r;
   logic [WIDTH-1:0]          retired_count_r;

   logic [WIDTH-1:0]          load_data_s;
   logic [WIDTH-1:0]          link_data_s;
   logic [WIDTH-1:0]          sel_data_s;
   logic                      sel_writes_s;
   logic                      rd_we_s;

   // Candidate sources; HI/LO selects read the value before any same-bundle write.
   always_comb begin
      load_data_s  = extract_load(bus.read_data_mem, bus.load_size_mem,
                                  bus.load_signed_mem, bus.byte_offset_mem);
      link_data_s  = bus.pc_mem + LINK_OFFSET_W;
      sel_data_s   = {WIDTH{1'b0}};
      sel_writes_s = 1'b0;
      case (bus.src_sel_mem)
         3'd1: begin
            sel_data_s   = bus.alu_result_mem;
            sel_writes_s = 1'b1;
         end
         3'd2: begin
            sel_data_s   = load_data_s;
            sel_writes_s = 1'b1;
         end
         3'd3: begin
            sel_data_s   = link_data_s;
            sel_writes_s = 1'b1;
         end
         3'd4: begin
            sel_data_s   = hi_r;
            sel_writes_s = 1'b1;
         end
         3'd5: begin
            sel_data_s   = lo_r;
            sel_writes_s = 1'b1;
         end
         default: begin
            sel_data_s   = {WIDTH{1'b0}};
            sel_writes_s = 1'b0;
         end
      endcase
      if (bus.rd_address_mem != {REG_ADDR_WIDTH{1'b0}}) begin
         rd_we_s = bus.valid_mem & bus.rd_mem & sel_writes_s;
      end else begin
         rd_we_s = 1'b0;
      end
   end

   // Stage register, HI/LO and retirement counter; stall holds everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_wb_r      <= 1'b0;
         pc_wb_r         <= {WIDTH{1'b0}};
         rd_wb_r         <= 1'b0;
         rd_address_wb_r <= {REG_ADDR_WIDTH{1'b0}};
         rd_data_wb_r    <= {WIDTH{1'b0}};
         hi_r            <= {WIDTH{1'b0}};
         lo_r            <= {WIDTH{1'b0}};
         retired_count_r <= {WIDTH{1'b0}};
      end else if (!stall) begin
         valid_wb_r      <= bus.valid_mem;
         pc_wb_r         <= bus.pc_mem;
         rd_wb_r         <= rd_we_s;
         rd_address_wb_r <= bus.rd_address_mem;
         rd_data_wb_r    <= sel_data_s;
         if (bus.valid_mem) begin
            if (bus.hilo_we_mem[1]) begin
               hi_r <= bus.hi_data_mem;
            end
            if (bus.hilo_we_mem[0]) begin
               lo_r <= bus.lo_data_mem;
            end
            retired_count_r <= retired_count_r + ONE_W;
         end
      end
   end

   assign bus.valid_wb      = valid_wb_r;
   assign bus.pc_wb         = pc_wb_r;
   assign bus.rd_wb         = rd_wb_r;
   assign bus.rd_address_wb = rd_address_wb_r;
   assign bus.rd_data_wb    = rd_data_wb_r;
   assign bus.hi            = hi_r;
   assign bus.lo            = lo_r;
   assign bus.retired_count = retired_count_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver pushes the expected
// post-edge state from a behavioural model; a monitor pops and compares
// just after each rising edge. Directed checks add literal expectations.
module tb_writeback_stage;

   logic clk;
   logic rst;
   logic stall;

   writeback_stage_if #(.WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

   writeback_stage #(.WIDTH(32), .REG_ADDR_WIDTH(5), .LINK_OFFSET(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .bus   (bus)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        rd;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] cnt;
   } snap_t;

   snap_t exp_q[$];
   snap_t m_state;
   int    checks = 0;
   int    errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load extraction using shifts and masks on the word.
   function automatic logic [31:0] model_load(input logic [31:0] w, input int size,
                                              input bit sgn, input int off);
      logic [31:0] v;
      if (size == 0) begin
         v = (w >> (8 * off)) & 32'h0000_00FF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 1) begin
         v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   // Advance the model by one edge using the currently driven inputs.
   task automatic model_step();
      snap_t n;
      int    sel;
      n = m_state;
      if (rst) begin
         n = '0;
      end else if (!stall) begin
         sel    = int'(bus.src_sel_mem);
         n.valid = bus.valid_mem;
         n.pc    = bus.pc_mem;
         n.addr  = bus.rd_address_mem;
         case (sel)
            1: n.data = bus.alu_result_mem;
            2: n.data = model_load(bus.read_data_mem, int'(bus.load_size_mem),
                                   bus.load_signed_mem, int'(bus.byte_offset_mem));
            3: n.data = bus.pc_mem + 32'd8;
            4: n.data = m_state.hi;
            5: n.data = m_state.lo;
            default: n.data = 32'd0;
         endcase
         n.rd = bus.valid_mem && bus.rd_mem && (bus.rd_address_mem != 5'd0) &&
                (sel >= 1) && (sel <= 5);
         if (bus.valid_mem) begin
            if (bus.hilo_we_mem[1]) n.hi = bus.hi_data_mem;
            if (bus.hilo_we_mem[0]) n.lo = bus.lo_data_mem;
            n.cnt = m_state.cnt + 32'd1;
         end
      end
      m_state = n;
      exp_q.push_back(n);
   endtask

   // One clock: record the expectation, then move to the next falling edge.
   task automatic do_cycle();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.valid_mem       = 1'b0;
      bus.pc_mem          = 32'd0;
      bus.rd_mem          = 1'b0;
      bus.rd_address_mem  = 5'd0;
      bus.src_sel_mem     = 3'd0;
      bus.alu_result_mem  = 32'd0;
      bus.read_data_mem   = 32'd0;
      bus.load_size_mem   = 2'd0;
      bus.load_signed_mem = 1'b0;
      bus.byte_offset_mem = 2'd0;
      bus.hilo_we_mem     = 2'd0;
      bus.hi_data_mem     = 32'd0;
      bus.lo_data_mem     = 32'd0;
   endtask

   task automatic alu_bundle(input logic [4:0] addr, input logic [31:0] val);
      idle_inputs();
      bus.valid_mem      = 1'b1;
      bus.pc_mem         = $urandom;
      bus.rd_mem         = 1'b1;
      bus.rd_address_mem = addr;
      bus.src_sel_mem    = 3'd1;
      bus.alu_result_mem = val;
   endtask

   task automatic load_bundle(input logic [1:0] size, input logic sgn, input logic [1:0] off);
      idle_inputs();
      bus.valid_mem       = 1'b1;
      bus.rd_mem          = 1'b1;
      bus.rd_address_mem  = 5'd3;
      bus.src_sel_mem     = 3'd2;
      bus.read_data_mem   = 32'h80FF_7F01;
      bus.load_size_mem   = size;
      bus.load_signed_mem = sgn;
      bus.byte_offset_mem = off;
   endtask

   task automatic random_inputs();
      bus.valid_mem       = ($urandom_range(0, 99) < 75);
      bus.pc_mem          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      bus.rd_mem          = 1'($urandom_range(0, 1));
      bus.rd_address_mem  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.src_sel_mem     = 3'($urandom_range(0, 7));
      bus.alu_result_mem  = $urandom;
      bus.read_data_mem   = $urandom;
      bus.load_size_mem   = 2'($urandom_range(0, 3));
      bus.load_signed_mem = 1'($urandom_range(0, 1));
      bus.byte_offset_mem = 2'($urandom_range(0, 3));
      bus.hilo_we_mem     = 2'($urandom_range(0, 3));
      bus.hi_data_mem     = $urandom;
      bus.lo_data_mem     = $urandom;
   endtask

   // Monitor: compare every field of the stage shortly after each rising edge.
   always @(posedge clk) begin
      snap_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("valid_wb",      {31'd0, bus.valid_wb}, {31'd0, e.valid});
         chk("pc_wb",         bus.pc_wb, e.pc);
         chk("rd_wb",         {31'd0, bus.rd_wb}, {31'd0, e.rd});
         chk("rd_address_wb", {27'd0, bus.rd_address_wb}, {27'd0, e.addr});
         chk("rd_data_wb",    bus.rd_data_wb, e.data);
         chk("hi",            bus.hi, e.hi);
         chk("lo",            bus.lo, e.lo);
         chk("retired_count", bus.retired_count, e.cnt);
      end
   end

   initial begin
      m_state = '0;
      rst     = 1'b1;
      stall   = 1'b0;
      alu_bundle(5'd5, 32'h1234_5678);

      // Reset held for two edges with a live bundle on the inputs.
      do_cycle();
      do_cycle();
      chk("rst_valid", {31'd0, bus.valid_wb}, 32'd0);
      chk("rst_data",  bus.rd_data_wb, 32'd0);
      chk("rst_cnt",   bus.retired_count, 32'd0);

      rst = 1'b0;
      do_cycle();
      chk("first_rd",   {31'd0, bus.rd_wb}, 32'd1);
      chk("first_addr", {27'd0, bus.rd_address_wb}, 32'd5);
      chk("first_data", bus.rd_data_wb, 32'h1234_5678);
      chk("first_cnt",  bus.retired_count, 32'd1);

      // Load extraction on 0x80FF_7F01.
      load_bundle(2'd0, 1'b1, 2'd3); do_cycle(); chk("ld_sb3", bus.rd_data_wb, 32'hFFFF_FF80);
      load_bundle(2'd0, 1'b0, 2'd2); do_cycle(); chk("ld_ub2", bus.rd_data_wb, 32'h0000_00FF);
      load_bundle(2'd1, 1'b1, 2'd1); do_cycle(); chk("ld_sh1", bus.rd_data_wb, 32'h0000_7F01);
      load_bundle(2'd1, 1'b1, 2'd2); do_cycle(); chk("ld_sh2", bus.rd_data_wb, 32'hFFFF_80FF);
      load_bundle(2'd2, 1'b1, 2'd3); do_cycle(); chk("ld_w",   bus.rd_data_wb, 32'h80FF_7F01);
      load_bundle(2'd3, 1'b0, 2'd1); do_cycle(); chk("ld_w3",  bus.rd_data_wb, 32'h80FF_7F01);

      // Link wrap and register zero.
      idle_inputs();
      bus.valid_mem = 1'b1; bus.rd_mem = 1'b1; bus.rd_address_mem = 5'd31;
      bus.src_sel_mem = 3'd3; bus.pc_mem = 32'hFFFF_FFFC;
      do_cycle();
      chk("link_wrap", bus.rd_data_wb, 32'h0000_0004);
      alu_bundle(5'd0, 32'hDEAD_BEEF);
      do_cycle();
      chk("r0_rd",    {31'd0, bus.rd_wb}, 32'd0);
      chk("r0_data",  bus.rd_data_wb, 32'hDEAD_BEEF);
      chk("r0_valid", {31'd0, bus.valid_wb}, 32'd1);

      // HI/LO: same-bundle read sees the old value, next bundle sees the new one.
      idle_inputs();
      bus.valid_mem = 1'b1; bus.rd_mem = 1'b1; bus.rd_address_mem = 5'd9;
      bus.src_sel_mem = 3'd4; bus.hilo_we_mem = 2'd3;
      bus.hi_data_mem = 32'hAAAA_0000; bus.lo_data_mem = 32'h0000_BBBB;
      do_cycle();
      chk("hi_old", bus.rd_data_wb, 32'd0);
      bus.hilo_we_mem = 2'd0;
      do_cycle();
      chk("hi_new", bus.rd_data_wb, 32'hAAAA_0000);
      chk("lo_reg", bus.lo, 32'h0000_BBBB);
      bus.src_sel_mem = 3'd5;
      do_cycle();
      chk("lo_sel", bus.rd_data_wb, 32'h0000_BBBB);
      bus.valid_mem = 1'b0; bus.hilo_we_mem = 2'd3;
      bus.hi_data_mem = 32'h1111_1111; bus.lo_data_mem = 32'h2222_2222;
      do_cycle();
      chk("bubble_hi",    bus.hi, 32'hAAAA_0000);
      chk("bubble_lo",    bus.lo, 32'h0000_BBBB);
      chk("bubble_valid", {31'd0, bus.valid_wb}, 32'd0);
      chk("bubble_rd",    {31'd0, bus.rd_wb}, 32'd0);

      // Stall freezes the stage while the inputs churn.
      alu_bundle(5'd7, 32'h0000_0055);
      do_cycle();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         random_inputs();
         bus.valid_mem = 1'b1; bus.hilo_we_mem = 2'd3;
         do_cycle();
         chk("stall_data", bus.rd_data_wb, 32'h0000_0055);
         chk("stall_hi",   bus.hi, 32'hAAAA_0000);
      end
      stall = 1'b0;
      alu_bundle(5'd8, 32'h0000_0066);
      do_cycle();
      chk("unstall_data", bus.rd_data_wb, 32'h0000_0066);

      // Counter wrap via a backdoor preload.
      idle_inputs();
      force dut.retired_count_r = 32'hFFFF_FFFE;
      #1;
      release dut.retired_count_r;
      m_state.cnt = 32'hFFFF_FFFE;
      alu_bundle(5'd1, 32'd1); do_cycle(); chk("wrap_ff", bus.retired_count, 32'hFFFF_FFFF);
      alu_bundle(5'd1, 32'd2); do_cycle(); chk("wrap_0",  bus.retired_count, 32'd0);
      alu_bundle(5'd1, 32'd3); do_cycle(); chk("wrap_1",  bus.retired_count, 32'd1);

      // Reset wins over stall.
      rst = 1'b1; stall = 1'b1;
      do_cycle();
      chk("rst_stall_cnt",  bus.retired_count, 32'd0);
      chk("rst_stall_hi",   bus.hi, 32'd0);
      chk("rst_stall_data", bus.rd_data_wb, 32'd0);
      rst = 1'b0; stall = 1'b0;

      // Randomised traffic against the model.
      for (int i = 0; i < 500; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         stall = ($urandom_range(0, 99) < 15);
         random_inputs();
         do_cycle();
      end

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
